// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready operand and result bundle for pipelined_cla_adder.
// The ovf result bit exists only when CLA_SIGNED_OVF_EN is defined.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 64
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef CLA_SIGNED_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
`else
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
  );
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
  );
`endif
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder {c_out, sum} = a + b + c_in, one WIDTH/STAGES slice per stage.
// Define CLA_SIGNED_OVF_EN to add the pipelined two's-complement overflow output ovf.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4,
  parameter int unsigned GROUP  = 4
) (
  input logic                  clk,
  input logic                  reset,
  pipelined_cla_adder_if.slave bus
);

  localparam int unsigned NS = (STAGES > 0) ? STAGES : 1;
  localparam int unsigned NG = (GROUP > 0) ? GROUP : 1;
  localparam int unsigned SW = WIDTH / NS;
  localparam int unsigned NGRP = SW / NG;

  if (STAGES < 1 || GROUP < 1 || (WIDTH % NS) != 0 || (SW % NG) != 0) begin : g_bad_cfg
    $error("pipelined_cla_adder: STAGES must divide WIDTH and GROUP must divide WIDTH/STAGES");
  end

  // Group generate/propagate with lookahead of the group carries; returns {carry_out, sum}.
  function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic ci);
    logic [SW-1:0] g, p, s;
    logic          gc, bg, bp;
    g  = x & y;
    p  = x ^ y;
    s  = '0;
    gc = ci;
    for (int unsigned grp = 0; grp < NGRP; grp++) begin
      bg = 1'b0;
      bp = 1'b1;
      for (int unsigned j = 0; j < NG; j++) begin
        s[grp*NG+j] = p[grp*NG+j] ^ (bg | (bp & gc));
        bg          = g[grp*NG+j] | (p[grp*NG+j] & bg);
        bp          = bp & p[grp*NG+j];
      end
      gc = bg | (bp & gc);
    end
    return {gc, s};
  endfunction

  logic [NS-1:0]    r_vld;
  logic [NS-1:0]    r_cy;
  logic [WIDTH-1:0] r_a   [NS];
  logic [WIDTH-1:0] r_b   [NS];
  logic [WIDTH-1:0] r_sum [NS];

  logic [NS-1:0]    w_vi;
  logic [NS-1:0]    w_ci;
  logic [NS-1:0]    w_cy;
  logic [WIDTH-1:0] w_a   [NS];
  logic [WIDTH-1:0] w_b   [NS];
  logic [WIDTH-1:0] w_si  [NS];
  logic [WIDTH-1:0] w_so  [NS];
  logic [SW:0]      w_res [NS];
  logic             w_stall;

  assign w_stall       = r_vld[NS-1] && !bus.out_ready;
  assign bus.in_ready  = reset && !w_stall;
  assign bus.out_valid = r_vld[NS-1];
  assign bus.sum       = r_sum[NS-1];
  assign bus.c_out     = r_cy[NS-1];

  always_comb begin
    w_vi[0] = bus.in_valid;
    w_ci[0] = bus.c_in;
    w_a[0]  = bus.a;
    w_b[0]  = bus.b;
    w_si[0] = '0;
    for (int unsigned k = 1; k < NS; k++) begin
      w_vi[k] = r_vld[k-1];
      w_ci[k] = r_cy[k-1];
      w_a[k]  = r_a[k-1];
      w_b[k]  = r_b[k-1];
      w_si[k] = r_sum[k-1];
    end
    for (int unsigned k = 0; k < NS; k++) begin
      w_res[k]            = cla_slice(w_a[k][k*SW +: SW], w_b[k][k*SW +: SW], w_ci[k]);
      w_so[k]             = w_si[k];
      w_so[k][k*SW +: SW] = w_res[k][SW-1:0];
      w_cy[k]             = w_res[k][SW];
    end
  end

  // Data registers load only with a valid op so the output holds across bubbles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld <= '0;
      r_cy  <= '0;
      for (int unsigned k = 0; k < NS; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else if (!w_stall) begin
      r_vld <= w_vi;
      for (int unsigned k = 0; k < NS; k++) begin
        if (w_vi[k]) begin
          r_a[k]   <= w_a[k];
          r_b[k]   <= w_b[k];
          r_sum[k] <= w_so[k];
          r_cy[k]  <= w_cy[k];
        end
      end
    end
  end

`ifdef CLA_SIGNED_OVF_EN
  logic w_ovf;
  logic r_ovf;

  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  assign w_ovf = w_a[NS-1][WIDTH-1] ^ w_b[NS-1][WIDTH-1] ^ w_so[NS-1][WIDTH-1] ^ w_cy[NS-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (!w_stall && w_vi[NS-1]) begin
      r_ovf <= w_ovf;
    end
  end

  assign bus.ovf = r_ovf;
`endif

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder computing {c_out, sum} = a + b + c_in.
- The operand is split into STAGES slices; slice k is added in pipeline stage k with group CLA logic. The carry is registered between stages, and input/output slices are skewed and deskewed internally.
- Streams one operation per cycle behind a valid/ready handshake with backpressure.
- Drop-in replacement for the combinational carry_lookahead_adder where WIDTH ≥ 64 breaks timing.

Parameters:
- WIDTH, 64: operand width in bits.
- STAGES, 4: pipeline stages. Must be ≥1 and must divide WIDTH.
- GROUP, 4: CLA group size inside a slice. Must divide WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry in
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result bits [WIDTH-1:0]
- c_out  output  1  carry out of bit WIDTH-1

Behaviour:
- Reset is sampled on the rising clk edge while reset==0.
  - After that edge: all stage valid bits =0, out_valid=0, sum=0, c_out=0, all internal operand/carry registers =0.
  - in_ready=0 while reset==0.
- Elaboration: an illegal STAGES/WIDTH/GROUP combination is an elaboration error via a generate-time $error.
- Accept/stall rules:
  - Accept occurs on an edge where in_valid && in_ready.
  - stall = out_valid && !out_ready.
  - in_ready = reset && !stall (combinational).
- Pipeline movement: single global enable = !stall. On stall, every stage register holds, and sum/c_out/out_valid stay stable. No bubble collapsing.
- Stage k (0..STAGES-1):
  - Adds slice k of the held operands with the incoming carry (c_in for k=0), using GROUP-bit generate/propagate with lookahead across groups.
  - Registers the sum slice, carry-out, the still-unconsumed upper operand slices, the lower result slices, and valid.
- Latency:
  - An operation accepted on edge N is presented at the outputs after edge N+STAGES-1.
  - With STAGES=1, the result is valid right after the acceptance edge.
- Throughput is 1/cycle when out_ready=1. Result order equals acceptance order.
- Output consumption: a result is consumed on an edge with out_valid && out_ready. If no new result arrives on that edge, out_valid drops; sum/c_out then hold their last value and are don't-care.
- in_valid=0 while not stalled inserts a bubble: the stage valid bit becomes 0.
- Arithmetic: all sums are modulo 2^WIDTH, and c_out is the true carry. Example: max+max+1 gives sum=all-ones, c_out=1.
- Simultaneous events:
  - reset==0 overrides stall and accept on the same edge.
  - Reset mid-operation discards every in-flight operation; none emerges after reset release.
- Inputs are ignored when not accepted. a/b/c_in need not be stable while in_ready=0.

Optional Feature:
- Macro: CLA_SIGNED_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), pipelined and stalled exactly with sum.
  - ovf = two's-complement overflow = carry into bit WIDTH-1 XOR c_out.
- Undefined: port absent, no extra registers, and behaviour otherwise identical.

Test Plan:
1. Reset: hold reset=0 for 3 edges with in_valid=1 → out_valid=0, sum=0, c_out=0, in_ready=0. Release → in_ready=1 in the same cycle; first output appears only from post-reset accepts.
2. Full carry ripple, WIDTH=64, STAGES=4: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1, accepted at edge N → after edge N+3, sum=0 and c_out=1. Also a=b=all-ones, c_in=1 → sum=all-ones, c_out=1.
3. Streaming: 100 random vectors back-to-back with out_ready=1 → 100 results on consecutive cycles, in order, each equal to a+b+c_in (65-bit compare), no gaps.
4. Backpressure: out_ready=0 for 5 cycles mid-stream with in_valid=1 → in_ready=0 for those cycles and sum/c_out stable. After release, the stream resumes with no loss or duplication; total count stays 100.
5. Reset mid-operation: 3 operations in flight, reset=0 for one edge → out_valid=0 after that edge, and none of the 3 results ever appear. The next accepted op yields the correct result with latency STAGES.
6. CLA_SIGNED_OVF_EN defined, check ovf for three cases:
   - a=64'h7FFF_FFFF_FFFF_FFFF, b=1, c_in=0 → ovf=1.
   - a=64'h8000_0000_0000_0000, b=64'hFFFF_FFFF_FFFF_FFFF → ovf=1.
   - a=1, b=64'hFFFF_FFFF_FFFF_FFFF → ovf=0, sum=0, c_out=1.
